// File: rtl/mining_pkg.sv
// Shared mining definitions: dispatcher state encoding and the default
// nonce width used by both the dispatcher and the hashing datapath.
package mining_pkg;

  // Nonce width shared with the hashing datapath.
  localparam int unsigned NONCE_W_DEFAULT = 32;

  // Default watchdog budget, in WAIT cycles, before a hash is retried.
  localparam int unsigned TIMEOUT_DEFAULT = 256;

  // Dispatcher control states.
  typedef enum logic [2:0] {
    DS_IDLE  = 3'd0,
    DS_ISSUE = 3'd1,
    DS_WAIT  = 3'd2,
    DS_RETRY = 3'd3,
    DS_ABORT = 3'd4
  } disp_state_e;

  // True for every state in which a job is in flight.
  function automatic logic state_is_busy(input disp_state_e s);
    return s != DS_IDLE;
  endfunction

  // True for the states that present a cancel to the hashing module.
  function automatic logic state_quits(input disp_state_e s);
    return (s == DS_RETRY) || (s == DS_ABORT);
  endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// Watchdog for the dispatcher's WAIT state: a clearable up-counter with a
// count enable. term_o flags the cycle in which the count reaches
// TIMEOUT-1, so the dispatcher leaves WAIT exactly TIMEOUT cycles after
// the ISSUE cycle that cleared the counter.
module dispatch_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;

  // Next count: clear has priority over the enable.
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc;
    end
  end

  // The flag looks at the incremented value so the terminal cycle is the
  // one in which the counter reaches TIMEOUT-1, not the one after it.
  assign term_o = en_i & ~clr_i & (cnt_inc == TERM);

  // Counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Mining-side initiator for the hashing module's begin/quit/done handshake.
// Walks a nonce range (inclusive, wrapping), issuing one hash per nonce,
// stops on the first winning nonce or at the end of the range, retries any
// hash whose completion never arrives, and cancels on host abort.
module nonce_dispatcher
  import mining_pkg::*;
#(
  parameter int unsigned NONCE_W = NONCE_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               job_start,
  input  logic               job_abort,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic               hash_done,
  input  logic               target_met,
  output logic               begin_hash,
  output logic               quit_hash,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               exhausted,
  output logic               timeout_err
);

  disp_state_e        state_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] end_q;
  logic [NONCE_W-1:0] found_nonce_q;
  logic               found_q;
  logic               exhausted_q;
  logic               timeout_err_q;
  logic               begin_q;
  logic               quit_q;
  logic               busy_q;

  logic [NONCE_W-1:0] nonce_inc;
  logic               at_end;
  logic               wd_clr;
  logic               wd_en;
  logic               wd_term;

  // Datapath helpers: next nonce (wraps naturally) and last-nonce compare.
  always_comb begin
    nonce_inc = nonce_q + 1'b1;
    at_end    = (nonce_q == end_q);
    wd_clr    = (state_q == DS_ISSUE);
    wd_en     = (state_q == DS_WAIT);
  end

  dispatch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (wd_clr),
    .en_i   (wd_en),
    .term_o (wd_term)
  );

  // Control FSM with nonce register and sticky result flags. The strobe
  // and busy registers are loaded with the value the next state decodes
  // to, so they always agree with state_q while staying registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= DS_IDLE;
      nonce_q       <= '0;
      end_q         <= '0;
      found_nonce_q <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      begin_q       <= 1'b0;
      quit_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      begin_q <= 1'b0;
      quit_q  <= 1'b0;
      case (state_q)
        DS_IDLE: begin
          if (job_start) begin
            nonce_q       <= nonce_start;
            end_q         <= nonce_end;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            exhausted_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            state_q       <= DS_ISSUE;
            begin_q       <= 1'b1;
            busy_q        <= 1'b1;
          end
        end

        DS_ISSUE: begin
          if (job_abort) begin
            state_q <= DS_ABORT;
            quit_q  <= 1'b1;
          end else begin
            state_q <= DS_WAIT;
          end
        end

        DS_WAIT: begin
          if (job_abort) begin
            state_q <= DS_ABORT;
            quit_q  <= 1'b1;
          end else if (hash_done && target_met) begin
            found_q       <= 1'b1;
            found_nonce_q <= nonce_q;
            state_q       <= DS_IDLE;
            busy_q        <= 1'b0;
          end else if (hash_done && at_end) begin
            exhausted_q <= 1'b1;
            state_q     <= DS_IDLE;
            busy_q      <= 1'b0;
          end else if (hash_done) begin
            nonce_q <= nonce_inc;
            state_q <= DS_ISSUE;
            begin_q <= 1'b1;
          end else if (wd_term) begin
            timeout_err_q <= 1'b1;
            state_q       <= DS_RETRY;
            quit_q        <= 1'b1;
          end
        end

        DS_RETRY: begin
          if (job_abort) begin
            state_q <= DS_ABORT;
            quit_q  <= 1'b1;
          end else begin
            state_q <= DS_ISSUE;
            begin_q <= 1'b1;
          end
        end

        DS_ABORT: begin
          state_q <= DS_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= DS_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output connections.
  always_comb begin
    begin_hash  = begin_q;
    quit_hash   = quit_q;
    nonce       = nonce_q;
    busy        = busy_q;
    found       = found_q;
    found_nonce = found_nonce_q;
    exhausted   = exhausted_q;
    timeout_err = timeout_err_q;
  end

endmodule

// File: doc/nonce_dispatcher.md
# nonce_dispatcher

Mining-side initiator for the hashing module's begin/quit/done handshake. It accepts a job (nonce range) from the top-level miner controller and issues one hash per nonce by pulsing `begin_hash`. It waits for `hash_done`, samples the target comparison, then advances the nonce until a winning nonce is found or the range is exhausted. A watchdog aborts and retries any hash whose `hash_done` never arrives. A host abort cancels the job through `quit_hash`.

## Interface
- `NONCE_W`, 32, nonce width.
- `TIMEOUT`, 256, max cycles spent in WAIT before a retry; must be ≥ 2.
- `clk` in 1: clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `job_start` in 1: start a job. Sampled only in IDLE.
- `job_abort` in 1: cancel the current job. Ignored in IDLE.
- `nonce_start` in NONCE_W: first nonce. Sampled with `job_start`.
- `nonce_end` in NONCE_W: last nonce, inclusive. Sampled with `job_start`.
- `hash_done` in 1: one-cycle completion pulse from the hashing module.
- `target_met` in 1: digest ≤ target. Valid only while `hash_done`=1.
- `begin_hash` out 1: one-cycle hash request.
- `quit_hash` out 1: one-cycle cancel to the hashing module.
- `nonce` out NONCE_W: nonce currently being hashed.
- `busy` out 1: high in every non-IDLE state.
- `found` out 1: sticky; a winning nonce exists.
- `found_nonce` out NONCE_W: winning nonce, valid while `found`=1.
- `exhausted` out 1: sticky; range finished with no winner.
- `timeout_err` out 1: sticky; at least one watchdog retry occurred in this job.

## Operation
- **Outputs:** all are registered or Moore-decoded from state; there are no Mealy paths.
- **States:** IDLE, ISSUE, WAIT, RETRY, ABORT.
- **IDLE**
  - On `job_start`: `nonce` ← `nonce_start`, `end_reg` ← `nonce_end`.
  - Clear `found`, `exhausted`, `timeout_err`, `found_nonce`.
  - Go to ISSUE.
- **ISSUE:** `begin_hash`=1. Clear the watchdog. Go to WAIT.
- **WAIT:** watchdog increments each cycle. Evaluate in this priority order:
  1. `job_abort` → ABORT.
  2. `hash_done` with `target_met`=1 → `found`←1, `found_nonce`←`nonce`, go to IDLE.
  3. `hash_done` with `nonce`==`end_reg` → `exhausted`←1, go to IDLE.
  4. `hash_done` otherwise → `nonce`←`nonce`+1 (mod 2^NONCE_W), go to ISSUE.
  5. Watchdog reaches TIMEOUT-1 → `timeout_err`←1, go to RETRY.
- **RETRY:** `quit_hash`=1, `nonce` unchanged. Go to ISSUE, or to ABORT if `job_abort`.
- **ABORT:** `quit_hash`=1. Go to IDLE. No sticky flag is set.
- **Abort in ISSUE:** `job_abort` → ABORT. The hashing module sees `begin_hash` then `quit_hash` on consecutive cycles.
- **Ignored inputs:**
  - `hash_done` outside WAIT.
  - `job_start` while busy.
  - `target_met` without `hash_done`.
- **Range wrap:** if `nonce_end` < `nonce_start`, counting wraps from all-ones to 0 and continues until `nonce`==`end_reg`.
- **Single nonce:** `nonce_start`==`nonce_end` hashes exactly one nonce.
- **Full range:** `nonce_end` = `nonce_start`-1 covers all 2^NONCE_W nonces.
- **Reset (any time, including mid-job):** state IDLE, all outputs 0, `nonce`=0, `found_nonce`=0, watchdog 0. `quit_hash` is not issued; the hashing module shares `n_rst`.

## Timing
- `job_start` sampled in cycle N → `begin_hash` high in N+1 → `busy` high from N+1.
- `hash_done` in cycle M, not final → `nonce` updated and `begin_hash` both in M+1. Per-nonce overhead beyond hashing latency is 2 cycles (ISSUE + `hash_done` cycle).
- Result latency: `found`/`exhausted` rise and `busy` falls in the cycle after the deciding `hash_done`.
- Watchdog: RETRY is entered TIMEOUT cycles after ISSUE if there is no `hash_done`. `quit_hash` is high 1 cycle, and `begin_hash` follows on the next cycle.
- Abort: `quit_hash` is high in the cycle after `job_abort` is sampled. `busy` is low the cycle after that.
- `begin_hash` and `quit_hash` are never high in the same cycle.

## Structure
- **Shared package `mining_pkg`:**
  - Dispatcher state enum (3-bit).
  - `NONCE_W` default constant, shared with the hashing datapath.
- **Sub-module `dispatch_watchdog`:** clearable up-counter with count enable and a parameterised terminal flag at TIMEOUT-1. Width is `$clog2(TIMEOUT)`.
- **In the top:** nonce register, incrementer, equality comparator, sticky flags.

## Test plan
- **Found:** start=0x10, end=0x1F; `hash_done` each time 5 cycles after `begin_hash`; `target_met` on the 4th done.
  - Expect `found`=1 and `found_nonce`=0x13.
  - Expect exactly 4 `begin_hash` pulses, then `busy`=0.
- **Exhausted with wrap:** start=0xFFFFFFFE, end=0x00000001, never `target_met`.
  - Expect nonces FFFFFFFE, FFFFFFFF, 0, 1 in that order.
  - Expect `exhausted`=1 and `found`=0.
- **Timeout retry:** TIMEOUT=8; drop the first `hash_done`.
  - Expect `quit_hash` 8 cycles after ISSUE, then `begin_hash` with the same nonce.
  - Expect `timeout_err`=1, and the job still completes normally.
- **Abort in WAIT:** `job_abort` and `hash_done`+`target_met` in the same cycle.
  - Expect ABORT wins: `quit_hash` pulse, `found`=0, `busy`=0 two cycles later.
- **Ignored start:** `job_start` with new values while busy → `nonce` sequence and `end_reg` unchanged.
- **Reset mid-WAIT:** drop `n_rst` during WAIT → all outputs 0 immediately; after release, a new job starts cleanly.
